line_buffer_3row: RTL and testbench

Upstream neighbour of the 3x3 morphology window stage. It turns a raster-order pixel stream into three vertically aligned row streams: the current row plus the same column from the two previous rows. These feed the window stage's three row inputs. It holds two line memories of PIC_WIDTH entries and tracks column and row position so that it presents only complete three-row columns. It also marks end-of-line for the consumer.

---
 rtl/line_buffer_3row.sv | 114 +++++++++++
 tb/tb_line_buffer_3row.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_3row.sv
// line_buffer_3row: converts a raster-order pixel stream into three vertically
// aligned rows (r-2, r-1, r) for a 3x3 window stage. Two line memories hold the
// previous two rows. A column is presented only once three rows are available.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   valid_in    - din carries a valid pixel this cycle
//   din         - pixel in raster order
//   valid_out   - dout1..dout3 hold a complete column (row >= 2)
//   dout1       - pixel from row r-2, same column
//   dout2       - pixel from row r-1, same column
//   dout3       - pixel from row r (registered din)
//   eol_out     - valid column is the last one of its line
module line_buffer_3row #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned PIC_WIDTH  = 320,
  parameter int unsigned PIC_HEIGHT = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             eol_out
);

  localparam int unsigned CW = 9;
  localparam int unsigned AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(PIC_HEIGHT - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [CW-1:0]    row_q, row_d;
  logic             valid_q, valid_d;
  logic             eol_q, eol_d;
  logic [WIDTH-1:0] dout1_q, dout1_d;
  logic [WIDTH-1:0] dout2_q, dout2_d;
  logic [WIDTH-1:0] dout3_q, dout3_d;

  // lineA holds row r-2, lineB holds row r-1; neither is reset
  logic [WIDTH-1:0] line_a_q [PIC_WIDTH];
  logic [WIDTH-1:0] line_b_q [PIC_WIDTH];

  logic [AW-1:0] addr;
  logic          col_last;
  logic          rows_full;

  assign addr      = col_q[AW-1:0];
  assign col_last  = (col_q == COL_LAST);
  assign rows_full = (row_q >= CW'(2));

  // Position tracking and output column selection
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    dout1_d = dout1_q;
    dout2_d = dout2_q;
    dout3_d = dout3_q;
    if (valid_in) begin
      dout3_d = din;
      dout2_d = line_b_q[addr];
      dout1_d = line_a_q[addr];
      valid_d = rows_full;
      eol_d   = rows_full && col_last;
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      dout1_q <= '0;
      dout2_q <= '0;
      dout3_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      dout1_q <= dout1_d;
      dout2_q <= dout2_d;
      dout3_q <= dout3_d;
    end
  end

  // Line memories shift down one row per column; reads above see pre-write data
  always_ff @(posedge clk) begin
    if (valid_in) begin
      line_a_q[addr] <= line_b_q[addr];
      line_b_q[addr] <= din;
    end
  end

  assign valid_out = valid_q;
  assign eol_out   = eol_q;
  assign dout1     = dout1_q;
  assign dout2     = dout2_q;
  assign dout3     = dout3_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Testbench for line_buffer_3row with a 4x4 picture: directed vector table,
// hand-written reset sequences, and randomized traffic against a frame model.
module tb_line_buffer_3row;

  localparam int unsigned W  = 24;
  localparam int unsigned PW = 4;
  localparam int unsigned PH = 4;

  logic         clk;
  logic         rst_n;
  logic         valid_in;
  logic [W-1:0] din;
  logic         valid_out;
  logic [W-1:0] dout1, dout2, dout3;
  logic         eol_out;

  line_buffer_3row #(.WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .eol_out   (eol_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           ev;
    bit           eeol;
    logic [W-1:0] e1, e2, e3;
    bit           chk_d;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(bit v, logic [W-1:0] d, bit ev, bit eeol,
                              logic [W-1:0] e1, logic [W-1:0] e2,
                              logic [W-1:0] e3, bit chk_d);
    vec_t t;
    t.v = v; t.d = d; t.ev = ev; t.eeol = eeol;
    t.e1 = e1; t.e2 = e2; t.e3 = e3; t.chk_d = chk_d;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid_out"}, W'(valid_out), W'(0));
    chk({tag, " eol_out"}, W'(eol_out), W'(0));
    chk({tag, " dout1"}, dout1, W'(0));
    chk({tag, " dout2"}, dout2, W'(0));
    chk({tag, " dout3"}, dout3, W'(0));
  endtask

  // Apply one input cycle and settle just after the active edge
  task automatic drive(input bit v, input logic [W-1:0] d);
    valid_in = v;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse with valid_in held high; outputs must read 0 throughout
  task automatic reset_pulse(input string tag);
    rst_n    = 1'b0;
    valid_in = 1'b1;
    din      = W'(24'hABC);
    #1;
    chk_zero({tag, " async"});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_zero($sformatf("%s cyc%0d", tag, i));
    end
    valid_in = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Behavioural model: pixel image of the current frame indexed by position
  logic [W-1:0] img [PH][PW];
  int           n_pix;
  logic [W-1:0] last_din;

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b1;
    din      = W'(24'h55);

    // Directed table for frames 0 and 1
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        add(1'b1, W'(r * 16 + c), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int c = 0; c < 4; c++)
      add(1'b1, W'(32 + c), 1'b1, c == 3, W'(c), W'(16 + c), W'(32 + c), 1'b1);
    for (int c = 0; c < 2; c++)
      add(1'b1, W'(48 + c), 1'b1, 1'b0, W'(16 + c), W'(32 + c), W'(48 + c), 1'b1);
    for (int g = 0; g < 5; g++)
      add(1'b0, W'(24'hFFF), 1'b0, 1'b0, W'(24'h11), W'(24'h21), W'(24'h31), 1'b1);
    for (int c = 2; c < 4; c++)
      add(1'b1, W'(48 + c), 1'b1, c == 3, W'(16 + c), W'(32 + c), W'(48 + c), 1'b1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        add(1'b1, W'(256 + r * 16 + c), 1'b0, 1'b0, '0, '0, '0, 1'b0);
    add(1'b1, W'(24'h120), 1'b1, 1'b0, W'(24'h100), W'(24'h110), W'(24'h120), 1'b1);

    // Initial reset with valid_in held high
    reset_pulse("init_rst");

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d valid_out", i), W'(valid_out), W'(tbl[i].ev));
      chk($sformatf("vec%0d eol_out", i), W'(eol_out), W'(tbl[i].eeol));
      if (tbl[i].chk_d) begin
        chk($sformatf("vec%0d dout1", i), dout1, tbl[i].e1);
        chk($sformatf("vec%0d dout2", i), dout2, tbl[i].e2);
        chk($sformatf("vec%0d dout3", i), dout3, tbl[i].e3);
      end
    end

    // Reset mid-row after pixel 0x121, then 12 fresh pixels
    drive(1'b1, W'(24'h121));
    chk("pre_rst dout1", dout1, W'(24'h101));
    chk("pre_rst dout3", dout3, W'(24'h121));
    reset_pulse("mid_rst");
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, W'(k));
      chk($sformatf("fresh%0d valid_out", k), W'(valid_out), W'(k >= 9));
      chk($sformatf("fresh%0d eol_out", k), W'(eol_out), W'(k == 12));
      if (k >= 9) begin
        chk($sformatf("fresh%0d dout1", k), dout1, W'(k - 8));
        chk($sformatf("fresh%0d dout2", k), dout2, W'(k - 4));
        chk($sformatf("fresh%0d dout3", k), dout3, W'(k));
      end
    end

    // Randomized traffic against the frame model
    reset_pulse("rnd_rst");
    n_pix    = 0;
    last_din = '0;
    for (int i = 0; i < 400; i++) begin
      bit           v;
      logic [W-1:0] d;
      bit           ev, eeol;
      logic [W-1:0] e1, e2;
      int           r, c;
      v  = ($urandom_range(0, 3) != 0);
      d  = W'($urandom);
      ev = 1'b0; eeol = 1'b0; e1 = '0; e2 = '0;
      if (v) begin
        r = n_pix / PW;
        c = n_pix % PW;
        img[r][c] = d;
        last_din  = d;
        if (r >= 2) begin
          ev   = 1'b1;
          eeol = (c == PW - 1);
          e1   = img[r - 2][c];
          e2   = img[r - 1][c];
        end
        n_pix = (n_pix + 1) % (PW * PH);
      end
      drive(v, d);
      chk($sformatf("rnd%0d valid_out", i), W'(valid_out), W'(ev));
      chk($sformatf("rnd%0d eol_out", i), W'(eol_out), W'(eeol));
      chk($sformatf("rnd%0d dout3", i), dout3, last_din);
      if (ev) begin
        chk($sformatf("rnd%0d dout1", i), dout1, e1);
        chk($sformatf("rnd%0d dout2", i), dout2, e2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
